// File: rtl/cross_bar_pkg.sv
// Shared widths, types and constants for the crossbar slave-port arbiter.
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SLAVE_W  = 2;   // slave-port select width across the crossbar
    localparam int IDX_W    = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACK
    } state_t;

    // Read data returned to a master whose slave never answered.
    localparam data_t TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cross_bar_rr_arb.sv
// Combinational round-robin picker: the first requester strictly after ptr,
// wrapping from MASTER_N-1 to 0.
module cross_bar_rr_arb
    import cross_bar_pkg::*;
(
    input  logic [MASTER_N-1:0] req,
    input  idx_t                ptr,
    output logic [MASTER_N-1:0] onehot,
    output idx_t                idx
);

    logic found;
    idx_t cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= MASTER_N; i++) begin
            cand = idx_t'((int'(ptr) + i) % MASTER_N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/cross_bar_slave_arb.sv
// Slave-port arbiter: grants one master at a time round-robin, issues a single
// request to the slave and returns its completion (or a timeout) to the master.
//
// state | meaning
// IDLE  | waiting for any m_req; picks and latches the winner
// REQ   | one-cycle slave_req; read data captured at end of cycle
// WAIT  | waiting for slave_ack, bounded by TIMEOUT_CYC
// ACK   | one-cycle m_ack to the granted master
module cross_bar_slave_arb
    import cross_bar_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [MASTER_N-1:0]  m_req,
    input  addr_t [MASTER_N-1:0] m_addr,
    input  logic [MASTER_N-1:0]  m_cmd,
    input  data_t [MASTER_N-1:0] m_wdata,
    output logic [MASTER_N-1:0]  m_ack,
    output data_t [MASTER_N-1:0] m_rdata,
    output logic                 slave_req,
    output addr_t                slave_addr,
    output logic                 slave_cmd,
    output data_t                slave_wdata,
    input  logic                 slave_ack,
    input  data_t                slave_rdata,
    output logic                 timeout_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    idx_t                grant_q, last_grant_q;
    idx_t                pick_idx;
    logic [MASTER_N-1:0] pick_oh;
    logic [7:0]          cnt_q;
    data_t               rdata_q;
    logic                to_q;
    logic                timeout_hit;

    cross_bar_rr_arb u_rr_arb (
        .req    (m_req),
        .ptr    (last_grant_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign timeout_hit = (state_q == ST_WAIT) && !slave_ack && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|m_req) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (slave_ack || timeout_hit) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs decode registered state only, so slave_ack never reaches them combinationally.
    always_comb begin
        m_ack       = '0;
        slave_req   = (state_q == ST_REQ);
        timeout_err = 1'b0;
        if (state_q == ST_ACK) begin
            m_ack[grant_q] = 1'b1;
            timeout_err    = to_q;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q      <= '0;
            last_grant_q <= idx_t'(MASTER_N - 1);
            cnt_q        <= '0;
            rdata_q      <= '0;
            to_q         <= 1'b0;
            slave_addr   <= '0;
            slave_cmd    <= 1'b0;
            slave_wdata  <= '0;
            m_rdata      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    to_q  <= 1'b0;
                    if (|m_req) begin
                        grant_q <= pick_idx;
                        for (int i = 0; i < MASTER_N; i++) begin
                            if (pick_oh[i]) begin
                                slave_addr  <= m_addr[i];
                                slave_cmd   <= m_cmd[i];
                                slave_wdata <= m_wdata[i];
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (!slave_cmd) rdata_q <= slave_rdata;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (slave_ack) begin
                        last_grant_q     <= grant_q;
                        m_rdata[grant_q] <= rdata_q;
                    end else if (timeout_hit) begin
                        rdata_q          <= TIMEOUT_RDATA;
                        to_q             <= 1'b1;
                        m_rdata[grant_q] <= TIMEOUT_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cross_bar_slave_arb.md
CROSS_BAR_SLAVE_ARB -- requirements
Module: cross_bar_slave_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: number of WAIT cycles without slave_ack before a timeout completion; legal range 2..255.
REQ-002 Clock clk; reset aresetn, asynchronous, active-low.
REQ-003 clk  input  1  block clock; all state updates on rising edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 m_req  input  [MASTER_N]  per-master request, already address-decoded for this slave port.
REQ-006 m_addr  input  [MASTER_N] x addr_t  per-master address.
REQ-007 m_cmd  input  [MASTER_N] x 1  per-master command: 1 = write, 0 = read.
REQ-008 m_wdata  input  [MASTER_N] x data_t  per-master write data.
REQ-009 m_ack  output  [MASTER_N]  per-master one-cycle completion pulse.
REQ-010 m_rdata  output  [MASTER_N] x data_t  read data returned, valid with m_ack.
REQ-011 slave_req  output  1  one-cycle request pulse to the slave.
REQ-012 slave_addr, slave_cmd, slave_wdata  output  addr_t, 1, data_t  registered copies of the granted master's fields.
REQ-013 slave_ack  input  1  slave completion.
REQ-014 slave_rdata  input  data_t  combinational read data, valid while slave_req=1 and slave_cmd=0.
REQ-015 timeout_err  output  1  one-cycle pulse on a timeout completion.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT and ACK.
REQ-017 IDLE: if any m_req is high, the block SHALL pick a winner round-robin, starting from index (last_grant+1) mod MASTER_N, latch its addr/cmd/wdata into slave_* and its index into grant, then go to REQ; if no m_req is high, it SHALL stay in IDLE.
REQ-018 REQ: slave_req SHALL be 1 for exactly this one cycle; when slave_cmd=0 the block SHALL capture slave_rdata into rdata_q at the end of the cycle; next state WAIT.
REQ-019 WAIT: slave_req SHALL be 0; a timeout counter SHALL count up from 0 in this state.
REQ-020 WAIT with slave_ack=1: the block SHALL go to ACK and update last_grant to grant.
REQ-021 WAIT with the counter reaching TIMEOUT_CYC-1 and no slave_ack: the block SHALL go to ACK, set rdata_q to 32'hDEAD_BEEF and pulse timeout_err in the ACK cycle.
REQ-022 ACK: m_ack[grant] SHALL be 1 for exactly one cycle and m_rdata[grant] SHALL equal rdata_q; next state IDLE.
REQ-023 m_req SHALL be ignored in REQ, WAIT and ACK.
REQ-024 A master SHALL deassert m_req on the edge after it sees m_ack, or hold it high to issue a back-to-back transaction.
REQ-025 Latency: m_req sampled in IDLE at cycle 0 SHALL produce m_ack at cycle 3 when the slave acks one cycle after slave_req.
REQ-026 For a non-granted index, m_ack SHALL be 0 and m_rdata SHALL hold its last value.
REQ-027 slave_ack in IDLE, REQ or ACK SHALL be ignored.
REQ-028 On writes, rdata_q SHALL be unchanged and m_rdata content is don't-care.
REQ-029 The round-robin pointer SHALL wrap from MASTER_N-1 to 0.
REQ-030 Simultaneous requests SHALL each be served within MASTER_N transactions, so no master starves.

Reset
REQ-031 Assertion of aresetn at any time, including mid-transaction, SHALL immediately force: state IDLE, slave_req 0, slave_addr/slave_cmd/slave_wdata 0, m_ack all 0, m_rdata all 0, timeout_err 0, counter 0, rdata_q 0, last_grant MASTER_N-1 (so master 0 wins first).
REQ-032 An aborted transaction SHALL NOT be replayed after reset; masters reissue it.

Structure
REQ-033 MASTER_N, ADDR_W, DATA_W, SLAVE_W, addr_t and data_t SHALL come from cross_bar_pkg.
REQ-034 The timeout return value 32'hDEAD_BEEF SHALL be a package constant.
REQ-035 The round-robin picker (request vector plus pointer in, one-hot and index out, purely combinational) SHALL be the sub-module cross_bar_rr_arb.
REQ-036 The implementation SHALL be 120-400 lines of RTL, with no latches and no combinational path from slave_ack to any output.

Verification
REQ-037 Single read: M0 reads addr 0x0000_0010 from a slave whose mem holds 0x1234_5678 -> slave_req pulses one cycle, m_ack[0] at cycle 3, m_rdata[0]=0x1234_5678.
REQ-038 Write then read: M1 writes 0xA5A5_A5A5 to addr 0x20, then reads addr 0x20 -> the read returns 0xA5A5_A5A5 and the slave sees exactly one write.
REQ-039 Contention: all MASTER_N=4 masters hold m_req from the first cycle after reset -> grant order 0,1,2,3,0 and every m_ack is a single cycle.
REQ-040 Timeout: slave_ack tied 0, M2 reads -> m_ack[2] and timeout_err at cycle 2+TIMEOUT_CYC, m_rdata[2]=0xDEAD_BEEF.
REQ-041 Reset mid-WAIT: aresetn low for 2 cycles while in WAIT -> all outputs 0 immediately; after release, M0 is granted first with no phantom ack.
REQ-042 Back-to-back: M3 holds m_req across 3 reads with no other requester -> 3 acks spaced 4 cycles apart.
